// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite word-addressed memory slave with a read-only window, one wait-state address and two-cycle ERROR replies.
// Optional RO_PRELOAD_EN: on reset, load each read-only word with 32'hA5A5_0000 | index.
module ahb_lite_mem_slave #(
   parameter int unsigned ADDRESS_DEPTH          = 1024,
   parameter int unsigned ADDRESS_WIDTH          = 32,
   parameter int unsigned DATA_WIDTH             = 32,
   parameter int unsigned READ_ONLY_START_ADDRESS = 32'h0,
   parameter int unsigned READ_ONLY_END_ADDRESS   = 32'h3,
   parameter int unsigned WAIT_ADDRESS           = 32'h5,
   parameter int unsigned WAIT_CYCLES            = 2
) (
   input  logic                     HCLK,
   input  logic                     HRESETn,
   input  logic                     HSEL,
   input  logic [ADDRESS_WIDTH-1:0] HADDR,
   input  logic                     HWRITE,
   input  logic [2:0]               HSIZE,
   input  logic [2:0]               HBURST,
   input  logic [1:0]               HTRANS,
   input  logic                     HREADY,
   input  logic [DATA_WIDTH-1:0]    HWDATA,
   output logic [DATA_WIDTH-1:0]    HRDATA,
   output logic                     HREADYOUT,
   output logic                     HRESP
);
   localparam int unsigned IDX_W = $clog2(ADDRESS_DEPTH);
   localparam logic [2:0]  HSIZE_WORD = 3'b010;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

   state_t                r_state, w_next;
   logic [3:0]            r_cnt;
   logic [IDX_W-1:0]      r_addr;
   logic                  r_write;
   logic                  r_wr_pend;
   logic [DATA_WIDTH-1:0] r_mem [ADDRESS_DEPTH];

   logic                  w_cap, w_err, w_is_wait, w_commit, w_rd_fwd;
   logic [IDX_W-1:0]      w_idx;
   logic                  w_unused;

   assign w_unused  = ^{HBURST, HTRANS[0]};
   assign HREADYOUT = (r_state == ST_IDLE) || (r_state == ST_ERR2);
   assign HRESP     = (r_state == ST_ERR1) || (r_state == ST_ERR2);

   // HTRANS[1] set means NON_SEQ or SEQ
   assign w_cap     = HSEL && HREADY && HTRANS[1] && HREADYOUT;
   assign w_idx     = HADDR[IDX_W-1:0];
   assign w_is_wait = (HADDR == ADDRESS_WIDTH'(WAIT_ADDRESS));
   // Range check as a single unsigned offset compare so a zero start bound is not a constant compare
   assign w_err     = (HADDR >= ADDRESS_WIDTH'(ADDRESS_DEPTH)) || (HSIZE != HSIZE_WORD) ||
                      (HWRITE && ((HADDR - ADDRESS_WIDTH'(READ_ONLY_START_ADDRESS)) <=
                                  ADDRESS_WIDTH'(READ_ONLY_END_ADDRESS - READ_ONLY_START_ADDRESS)));
   assign w_commit  = r_wr_pend && (r_state == ST_IDLE);
   assign w_rd_fwd  = w_commit && (r_addr == w_idx);

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_WAIT: if (r_cnt == 4'd1) w_next = ST_IDLE;
         ST_ERR1: w_next = ST_ERR2;
         default: begin
            w_next = ST_IDLE;
            if (w_cap) begin
               if (w_err)          w_next = ST_ERR1;
               else if (w_is_wait) w_next = ST_WAIT;
            end
         end
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         r_state   <= ST_IDLE;
         r_cnt     <= 4'd0;
         r_addr    <= '0;
         r_write   <= 1'b0;
         r_wr_pend <= 1'b0;
         HRDATA    <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == ST_WAIT) r_cnt <= r_cnt - 4'd1;
         if (w_commit) r_wr_pend <= 1'b0;
         if (w_cap) begin
            r_addr    <= w_idx;
            r_write   <= HWRITE;
            r_cnt     <= 4'(WAIT_CYCLES);
            r_wr_pend <= HWRITE && !w_err;
            if (!HWRITE) begin
               if (w_err)          HRDATA <= '0;
               else if (!w_is_wait) HRDATA <= w_rd_fwd ? HWDATA : r_mem[w_idx];
            end
         end
         if ((r_state == ST_WAIT) && (r_cnt == 4'd1) && !r_write) HRDATA <= r_mem[r_addr];
      end
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
`ifdef RO_PRELOAD_EN
         for (int unsigned i = READ_ONLY_START_ADDRESS; i <= READ_ONLY_END_ADDRESS; i++)
            r_mem[IDX_W'(i)] <= DATA_WIDTH'(32'hA5A5_0000 | i);
`endif
      end else if (w_commit) begin
         r_mem[r_addr] <= HWDATA;
      end
   end
endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Directed self-checking bench for ahb_lite_mem_slave; HREADY is looped back from HREADYOUT (single slave).
module tb_ahb_lite_mem_slave;
   localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10;

   logic        HCLK = 1'b0;
   logic        HRESETn, HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [2:0]  HSIZE, HBURST;
   logic [1:0]  HTRANS;
   int          n_checks = 0;
   int          n_errors = 0;
   int          n_wait;

   assign HREADY = HREADYOUT;
   always #5 HCLK = ~HCLK;

   ahb_lite_mem_slave dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
      .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS), .HREADY(HREADY), .HWDATA(HWDATA),
      .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge HCLK);
      @(negedge HCLK);
   endtask

   task automatic ap(input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [1:0] tr);
      HSEL = 1'b1; HADDR = a; HWRITE = w; HSIZE = sz; HTRANS = tr;
   endtask

   task automatic idle();
      HSEL = 1'b0; HTRANS = T_IDLE;
   endtask

   task automatic count_wait(input string tag, output int n);
      n = 0;
      while (HREADYOUT !== 1'b1 && n < 20) begin
         n++;
         cyc();
      end
      if (n >= 20) chk({tag, "_timeout"}, HREADYOUT, 1'b1);
   endtask

   task automatic write0(input logic [31:0] a, input logic [31:0] d, input string tag);
      ap(a, 1'b1, 3'b010, T_NSEQ);
      cyc();
      HWDATA = d; idle();
      chk({tag, "_rdy"}, HREADYOUT, 1'b1);
      chk({tag, "_resp"}, HRESP, 1'b0);
      cyc();
   endtask

   task automatic read0(input logic [31:0] a, input logic [31:0] exp, input string tag);
      ap(a, 1'b0, 3'b010, T_NSEQ);
      cyc();
      idle();
      chk({tag, "_rdy"}, HREADYOUT, 1'b1);
      chk({tag, "_data"}, HRDATA, exp);
   endtask

   task automatic read_wait(input logic [31:0] a, input logic [31:0] exp, input string tag);
      ap(a, 1'b0, 3'b010, T_NSEQ);
      cyc();
      idle();
      count_wait(tag, n_wait);
      chk({tag, "_nwait"}, n_wait, 32'd2);
      chk({tag, "_resp"}, HRESP, 1'b0);
      chk({tag, "_data"}, HRDATA, exp);
   endtask

   task automatic err_seq(input string tag);
      chk({tag, "_e1_rdy"}, HREADYOUT, 1'b0);
      chk({tag, "_e1_resp"}, HRESP, 1'b1);
      cyc();
      chk({tag, "_e2_rdy"}, HREADYOUT, 1'b1);
      chk({tag, "_e2_resp"}, HRESP, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HWRITE = 1'b0; HSIZE = 3'b010;
      HBURST = 3'b000; HTRANS = T_IDLE; HWDATA = '0;
      @(negedge HCLK);
      cyc(); cyc();
      chk("rst_rdy", HREADYOUT, 1'b1);
      chk("rst_resp", HRESP, 1'b0);
      chk("rst_data", HRDATA, 32'h0);
      HRESETn = 1'b1;

      write0(32'h10, 32'hDEADBEEF, "w10");
      read0(32'h10, 32'hDEADBEEF, "r10");

      // write into read-only window
      ap(32'h2, 1'b1, 3'b010, T_NSEQ);
      cyc();
      HWDATA = 32'h1234; idle();
      err_seq("ro_wr");
      cyc();
      chk("ro_wr_done_resp", HRESP, 1'b0);
`ifdef RO_PRELOAD_EN
      read0(32'h2, 32'hA5A5_0002, "ro_rd");
`endif

      // wait-state write then wait-state read
      ap(32'h5, 1'b1, 3'b010, T_NSEQ);
      cyc();
      HWDATA = 32'h55AA; idle();
      count_wait("w5", n_wait);
      chk("w5_nwait", n_wait, 32'd2);
      chk("w5_resp", HRESP, 1'b0);
      cyc();
      read_wait(32'h5, 32'h55AA, "r5");

      // pipelined write then read of the same word
      write0(32'h20, 32'h1, "w20a");
      ap(32'h20, 1'b1, 3'b010, T_NSEQ);
      cyc();
      HWDATA = 32'hCAFE0001;
      ap(32'h20, 1'b0, 3'b010, T_NSEQ);
      cyc();
      idle();
      chk("fwd_data", HRDATA, 32'hCAFE0001);
      chk("fwd_rdy", HREADYOUT, 1'b1);
      read0(32'h20, 32'hCAFE0001, "r20");

      // out-of-range read
      ap(32'd1024, 1'b0, 3'b010, T_NSEQ);
      cyc();
      idle();
      chk("oor_data", HRDATA, 32'h0);
      err_seq("oor");
      cyc();
      chk("oor_done_resp", HRESP, 1'b0);

      // bad-size read, then a new capture during the second error cycle
      read0(32'h10, 32'hDEADBEEF, "r10b");
      ap(32'h10, 1'b0, 3'b000, T_NSEQ);
      cyc();
      idle();
      chk("sz_data", HRDATA, 32'h0);
      err_seq("sz");
      ap(32'h10, 1'b0, 3'b010, T_NSEQ);
      cyc();
      idle();
      chk("err2cap_resp", HRESP, 1'b0);
      chk("err2cap_data", HRDATA, 32'hDEADBEEF);

      // bad-size write must not modify memory
      ap(32'h10, 1'b1, 3'b000, T_NSEQ);
      cyc();
      HWDATA = 32'hBAD0BAD0; idle();
      err_seq("szw");
      cyc();
      read0(32'h10, 32'hDEADBEEF, "r10c");

      // reset during first wait cycle of a write
      ap(32'h5, 1'b1, 3'b010, T_NSEQ);
      cyc();
      HWDATA = 32'h0BADF00D; idle();
      chk("rw_wait_rdy", HREADYOUT, 1'b0);
      HRESETn = 1'b0;
      cyc();
      HRESETn = 1'b1;
      chk("rw_rdy", HREADYOUT, 1'b1);
      chk("rw_resp", HRESP, 1'b0);
      chk("rw_data", HRDATA, 32'h0);
      cyc();
      read_wait(32'h5, 32'h55AA, "r5b");

      // BUSY beat: zero-wait OKAY, no access
      ap(32'h10, 1'b1, 3'b010, T_BUSY);
      cyc();
      HWDATA = 32'hFFFFFFFF; idle();
      chk("busy_rdy", HREADYOUT, 1'b1);
      chk("busy_resp", HRESP, 1'b0);
      chk("busy_data", HRDATA, 32'h55AA);
      cyc();
      read0(32'h10, 32'hDEADBEEF, "r10d");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/ahb_lite_mem_slave.md
Name: ahb_lite_mem_slave

Overview:
- AHB-Lite memory slave. It is the downstream consumer of the shared AHB-Lite defines: slave constants and HTRANS encodings.
- Sits on the bus behind the decoder, which drives HSEL.
- Word-addressed storage with a read-only region, one address that inserts wait states, and two-cycle ERROR responses for illegal accesses.
- Serves as the DUT for master and bus-level verification.

Parameters:
- ADDRESS_DEPTH, 1024, number of 32-bit words; valid indices are 0..ADDRESS_DEPTH-1.
- ADDRESS_WIDTH, 32, HADDR width.
- DATA_WIDTH, 32, HWDATA/HRDATA width.
- READ_ONLY_START_ADDRESS, 32'h0, first word index of the read-only region (inclusive).
- READ_ONLY_END_ADDRESS, 32'h3, last word index of the read-only region (inclusive).
- WAIT_ADDRESS, 32'h5, word index whose accesses insert wait states.
- WAIT_CYCLES, 2, number of HREADYOUT-low cycles for a WAIT_ADDRESS access; legal range 1..15.

Ports:
- HCLK  in  1  bus clock; all logic is on the rising edge.
- HRESETn  in  1  reset; synchronous, active-low.
- HSEL  in  1  slave select from the decoder.
- HADDR  in  ADDRESS_WIDTH  word index; no byte addressing.
- HWRITE  in  1  1=write, 0=read.
- HSIZE  in  HSIZE_WIDTH(3)  transfer size; only 3'b010 is legal.
- HBURST  in  BURST_SIZE(3)  burst type; accepted and ignored, each beat is treated independently.
- HTRANS  in  TRANSFER_TYPE(2)  IDLE/BUSY/NON_SEQ/SEQ.
- HREADY  in  1  global bus ready, i.e. the muxed HREADYOUT.
- HWDATA  in  DATA_WIDTH  write data, valid in the data phase.
- HRDATA  out  DATA_WIDTH  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0=OKAY, 1=ERROR.

Behaviour:
- Reset (HRESETn=0 at a clock edge):
  - HREADYOUT=1, HRESP=0, HRDATA=0.
  - State goes to ST_IDLE; latched address-phase registers are cleared.
  - Memory is not cleared, except as given under Optional Feature.
  - Reset mid-wait or mid-error aborts the transfer with no memory write.
- Address-phase capture:
  - Occurs when HSEL=1, HREADY=1 and HTRANS is NON_SEQ or SEQ.
  - Latches HADDR, HWRITE, HSIZE.
  - HTRANS IDLE/BUSY, or HSEL=0 with HREADY=1: no access; the data phase is a zero-wait OKAY.
  - HREADY=0: nothing is captured.
- Error classification, decided at capture, in priority order:
  - HADDR >= ADDRESS_DEPTH.
  - HSIZE != 3'b010.
  - Write with READ_ONLY_START_ADDRESS <= HADDR <= READ_ONLY_END_ADDRESS.
  - Any of these goes to ST_ERR1. Memory is never modified by an errored transfer.
- States:
  - ST_IDLE: HREADYOUT=1, HRESP=0.
    - Capture to WAIT_ADDRESS with no error -> ST_WAIT, counter = WAIT_CYCLES.
    - Capture with an error -> ST_ERR1.
    - Any other capture, or no capture -> stay in ST_IDLE.
  - ST_WAIT: HREADYOUT=0, HRESP=0.
    - Counter decrements each cycle; at counter==1 -> ST_IDLE.
    - The data phase completes on the next cycle, which has HREADYOUT=1.
    - Read data is driven on that completing cycle.
  - ST_ERR1: HREADYOUT=0, HRESP=1 -> ST_ERR2 unconditionally.
  - ST_ERR2: HREADYOUT=1, HRESP=1.
    - A new address phase may be captured this cycle and is classified normally.
    - Next state is ST_IDLE, ST_WAIT or ST_ERR1 accordingly.
- Reads:
  - HRDATA is registered, loaded from mem[HADDR] at capture.
  - For a WAIT_ADDRESS read, the load happens on the last wait cycle.
  - Zero-wait reads are therefore valid in the cycle immediately after the address phase.
  - HRDATA holds its value until the next read load.
  - HRDATA is 0 after an errored read.
- Writes:
  - HWDATA is written to mem[latched addr] on the clock edge ending the data phase, i.e. the cycle with HREADYOUT=1 in ST_IDLE for a pending non-error write.
- Write-read forwarding:
  - Case: a read captures the same index whose write data phase completes in the same cycle.
  - HRDATA loads HWDATA, not the stale mem contents.
- Back-to-back pipelined transfers run at one per cycle, except for WAIT_ADDRESS accesses and errors.

Optional Feature:
- Macro: RO_PRELOAD_EN.
- Defined: on reset, mem[i] = 32'hA5A5_0000 | i for every i in the read-only region; other words are untouched.
- Not defined: no preload; read-only words are uninitialized (X in simulation) until loaded by a $readmemh backdoor.

Test Plan:
- Write NON_SEQ HADDR=0x10 HWDATA=32'hDEADBEEF, then read 0x10 -> both OKAY with zero wait; HRDATA=32'hDEADBEEF one cycle after the read address phase.
- With RO_PRELOAD_EN, write 0x2 with 32'h1234 -> one cycle HREADYOUT=0/HRESP=1, then one cycle HREADYOUT=1/HRESP=1; subsequent read 0x2 returns 32'hA5A5_0002.
- Read HADDR=0x5 -> HREADYOUT low for exactly 2 cycles, then high with HRESP=0 and HRDATA=mem[5].
- Pipelined write 0x20=32'hCAFE0001 immediately followed by read 0x20 -> read returns 32'hCAFE0001 via forwarding.
- HADDR=1024 read, and HSIZE=3'b000 read at 0x10 -> each gets a two-cycle ERROR; HRDATA=0; mem[0x10] unchanged.
- Assert HRESETn=0 during the first wait cycle of a write to 0x5 -> next cycle HREADYOUT=1, HRESP=0, HRDATA=0; mem[5] unchanged. A BUSY beat gets a zero-wait OKAY with no access.
